// File: rtl/vga_tile_pkg.sv
// Shared constants, payload types and helpers for the VGA tile renderer.
package vga_tile_pkg;

  localparam int unsigned TILE_COLS    = 40;
  localparam int unsigned TILE_ROWS    = 30;
  localparam int unsigned TILE_COUNT   = TILE_COLS * TILE_ROWS;
  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned TILE_W       = 8;
  localparam int unsigned GLYPH_IDX_W  = 6;
  localparam int unsigned GLYPH_ROW_W  = 4;
  localparam int unsigned GLYPH_ADDR_W = GLYPH_IDX_W + GLYPH_ROW_W;
  localparam int unsigned GLYPH_W      = 16;
  localparam int unsigned PAL_W        = 2;
  localparam int unsigned COLOUR_W     = 8;

  typedef struct packed {
    logic [GLYPH_IDX_W-1:0] glyph;
    logic [PAL_W-1:0]       pal;
  } tile_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  localparam logic [COLOUR_W-1:0] PALETTE [4] = '{8'hE0, 8'h1C, 8'h03, 8'hFF};
  localparam logic [COLOUR_W-1:0] BG_COLOUR   = 8'h00;
  localparam logic [COLOUR_W-1:0] GRID_COLOUR = 8'b010_010_01;

  // row*40 + col built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] tile_index(input logic [4:0] row,
                                                   input logic [5:0] col);
    return (ADDR_W'(row) << 5) + (ADDR_W'(row) << 3) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_tile_clear_fsm.sv
// Clear-screen sequencer: walks the whole tile map writing zeros whenever the RAM port is free.
module vga_tile_clear_fsm
  import vga_tile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              slot_free,
  output logic              clear_busy,
  output logic              clr_we_c,
  output logic [ADDR_W-1:0] clr_ptr
);

  clr_state_t        state;
  clr_state_t        state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLR_IDLE;
      clr_ptr    <= '0;
      clear_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_ptr    <= ptr_nxt;
      clear_busy <= (state_nxt != CLR_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    clr_we_c  = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (clear_req) begin
          state_nxt = CLR_RUN;
          ptr_nxt   = '0;
        end
      end
      CLR_RUN: begin
        if (slot_free) begin
          clr_we_c = 1'b1;
          if (clr_ptr == ADDR_W'(TILE_COUNT - 1)) begin
            state_nxt = CLR_IDLE;
          end else begin
            ptr_nxt = clr_ptr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map renderer: tile RAM arbitration, glyph lookup and a 3-stage RGB/sync pipeline.
// Optional grid overlay is built when GRID_OVERLAY_EN is defined.
module vga_tile_renderer
  import vga_tile_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        counter_x,
  input  logic [CNT_W-1:0]        counter_y,
  input  logic                    h_sync_n_in,
  input  logic                    v_sync_n_in,
  output logic [ADDR_W-1:0]       tile_addr,
  output logic                    tile_we,
  output logic [TILE_W-1:0]       tile_wdata,
  input  logic [TILE_W-1:0]       tile_rdata,
  output logic [GLYPH_ADDR_W-1:0] glyph_addr,
  input  logic [GLYPH_W-1:0]      glyph_data,
  input  logic                    host_wr_valid,
  input  logic [ADDR_W-1:0]       host_wr_addr,
  input  logic [TILE_W-1:0]       host_wr_data,
  output logic                    host_wr_ready,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic [2:0]              vga_r,
  output logic [2:0]              vga_g,
  output logic [1:0]              vga_b,
  output logic                    vga_h_sync_n,
  output logic                    vga_v_sync_n
);

  logic              active0;
  logic [ADDR_W-1:0] pix_addr;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_ptr;

  logic [3:0]        x1;
  logic [3:0]        y1;
  logic              act1;
  logic [3:0]        x2;
  logic [PAL_W-1:0]  pal2;
  logic              act2;
`ifdef GRID_OVERLAY_EN
  logic [3:0]        y2;
`endif
  tile_t             tile;
  logic              pix;
  logic [COLOUR_W-1:0] colour;
  rgb_t              rgb_q;
  logic [1:0]        h_sync_d;
  logic [1:0]        v_sync_d;

  assign active0  = (counter_x < CNT_W'(H_ACTIVE)) && (counter_y < CNT_W'(V_ACTIVE));
  assign pix_addr = tile_index(counter_y[8:4], counter_x[9:4]);

  vga_tile_clear_fsm u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .slot_free  (!active0),
    .clear_busy (clear_busy),
    .clr_we_c   (clr_we),
    .clr_ptr    (clr_ptr)
  );

  // RAM port owner: renderer during active video, else clear sequencer, else host.
  // A pending clear_req already locks the host out in the cycle it arrives.
  always_comb begin
    tile_addr     = '0;
    tile_we       = 1'b0;
    tile_wdata    = '0;
    host_wr_ready = 1'b0;
    if (!reset) begin
      if (active0) begin
        tile_addr = pix_addr;
      end else if (clr_we) begin
        tile_addr = clr_ptr;
        tile_we   = 1'b1;
      end else if (host_wr_valid && !clear_busy && !clear_req) begin
        host_wr_ready = 1'b1;
        tile_addr     = host_wr_addr;
        tile_wdata    = host_wr_data;
        tile_we       = (host_wr_addr < ADDR_W'(TILE_COUNT));
      end
    end
  end

  assign tile       = tile_t'(tile_rdata);
  assign glyph_addr = reset ? '0 : {tile.glyph, y1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1   <= '0;
      y1   <= '0;
      act1 <= 1'b0;
      x2   <= '0;
      pal2 <= '0;
      act2 <= 1'b0;
`ifdef GRID_OVERLAY_EN
      y2   <= '0;
`endif
    end else begin
      x1   <= counter_x[3:0];
      y1   <= counter_y[3:0];
      act1 <= active0;
      x2   <= x1;
      pal2 <= tile.pal;
      act2 <= act1;
`ifdef GRID_OVERLAY_EN
      y2   <= y1;
`endif
    end
  end

  // Bit 15 of the glyph row is the leftmost pixel of the tile.
  always_comb begin
    pix    = glyph_data[4'd15 - x2];
    colour = pix ? PALETTE[pal2] : BG_COLOUR;
`ifdef GRID_OVERLAY_EN
    if ((x2 == 4'd0) || (y2 == 4'd0)) colour = GRID_COLOUR;
`endif
    if (!act2) colour = '0;
  end

  // Syncs arrive one cycle late, so two stages line them up with the RGB register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q    <= '0;
      h_sync_d <= 2'b11;
      v_sync_d <= 2'b11;
    end else begin
      rgb_q    <= rgb_t'(colour);
      h_sync_d <= {h_sync_d[0], h_sync_n_in};
      v_sync_d <= {v_sync_d[0], v_sync_n_in};
    end
  end

  assign vga_r        = rgb_q.r;
  assign vga_g        = rgb_q.g;
  assign vga_b        = rgb_q.b;
  assign vga_h_sync_n = h_sync_d[1];
  assign vga_v_sync_n = v_sync_d[1];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer with behavioural tile RAM and glyph ROM.
module tb_vga_tile_renderer;
  import vga_tile_pkg::*;

  localparam int BX = 1000;
  localparam int BY = 500;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter_x, counter_y;
  logic        h_sync_n_in, v_sync_n_in;
  logic [10:0] tile_addr;
  logic        tile_we;
  logic [7:0]  tile_wdata, tile_rdata;
  logic [9:0]  glyph_addr;
  logic [15:0] glyph_data;
  logic        host_wr_valid;
  logic [10:0] host_wr_addr;
  logic [7:0]  host_wr_data;
  logic        host_wr_ready;
  logic        clear_req, clear_busy;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        vga_h_sync_n, vga_v_sync_n;

  vga_tile_renderer dut (
    .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
    .h_sync_n_in(h_sync_n_in), .v_sync_n_in(v_sync_n_in),
    .tile_addr(tile_addr), .tile_we(tile_we), .tile_wdata(tile_wdata), .tile_rdata(tile_rdata),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready), .clear_req(clear_req), .clear_busy(clear_busy),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_h_sync_n(vga_h_sync_n), .vga_v_sync_n(vga_v_sync_n)
  );

  always #5 clk = ~clk;

  logic [7:0]  tile_mem  [0:2047];
  logic [15:0] glyph_rom [0:1023];

  always @(posedge clk) begin
    if (tile_we) tile_mem[tile_addr] <= tile_wdata;
    tile_rdata <= tile_mem[tile_addr];
    glyph_data <= glyph_rom[glyph_addr];
  end

  typedef struct { int due; logic [7:0] rgb; logic hs; logic vs; } pix_exp_t;
  typedef struct { logic [10:0] addr; logic [7:0] data; } wr_exp_t;
  pix_exp_t pq[$];
  wr_exp_t  wq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [9:0]  last_x, last_y;
  logic        nxt_valid, nxt_clr;
  logic [10:0] nxt_addr;
  logic [7:0]  nxt_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ov(input int x, input int y, input logic [7:0] c);
`ifdef GRID_OVERLAY_EN
    if (x < 640 && y < 480 && ((x % 16) == 0 || (y % 16) == 0)) return 8'h49;
`endif
    return c;
  endfunction

  // One pixel-clock of stimulus; the sync generator model lags its counters by one cycle.
  task automatic step(input int x, input int y, input logic [7:0] rgb);
    pix_exp_t e;
    @(posedge clk); #1;
    h_sync_n_in   = !(last_x >= 655 && last_x <= 750);
    v_sync_n_in   = !(last_y >= 490 && last_y <= 491);
    counter_x     = 10'(x);
    counter_y     = 10'(y);
    last_x        = counter_x;
    last_y        = counter_y;
    host_wr_valid = nxt_valid;
    host_wr_addr  = nxt_addr;
    host_wr_data  = nxt_data;
    clear_req     = nxt_clr;
    e.due = cyc + 3;
    e.rgb = rgb;
    e.hs  = !(x >= 655 && x <= 750);
    e.vs  = !(y >= 490 && y <= 491);
    pq.push_back(e);
    @(negedge clk);
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    wr_exp_t w;
    w.addr = 11'(addr);
    w.data = data;
    wq.push_back(w);
  endtask

  task automatic host_write(input int addr, input logic [7:0] data);
    nxt_valid = 1'b1;
    nxt_addr  = 11'(addr);
    nxt_data  = data;
    if (addr < 1200) push_wr(addr, data);
    step(BX, BY, 8'h00);
    chk("host_ready", host_wr_ready, 1);
    chk("host_we", tile_we, (addr < 1200));
    nxt_valid = 1'b0;
  endtask

  // Monitor: pipeline outputs against due-cycle expectations, RAM writes against the write queue.
  always @(negedge clk) begin
    pix_exp_t pe;
    wr_exp_t  wx;
    if (!reset) begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pe = pq.pop_front();
        chk("pix_rgb", {vga_r, vga_g, vga_b}, pe.rgb);
        chk("pix_hsync", vga_h_sync_n, pe.hs);
        chk("pix_vsync", vga_v_sync_n, pe.vs);
      end
      if (tile_we) begin
        chk("we_outside_active", (counter_x < 640 && counter_y < 480), 0);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%0h (cycle %0d)", tile_addr, tile_wdata, cyc);
        end else begin
          wx = wq.pop_front();
          chk("write_addr", tile_addr, wx.addr);
          chk("write_data", tile_wdata, wx.data);
        end
      end
    end
  end

  initial begin
    int k;
    int nz;
    for (int i = 0; i < 2048; i++) tile_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) glyph_rom[i] = 16'h0000;
    glyph_rom[16] = 16'h8000;   // glyph 1, row 0
    glyph_rom[37] = 16'h8000;   // glyph 2, row 5
    tile_rdata = 8'h00;
    glyph_data = 16'h0000;
    reset = 1'b1;
    counter_x = 10'(BX); counter_y = 10'(BY);
    last_x = 10'(BX);    last_y = 10'(BY);
    h_sync_n_in = 1'b1;  v_sync_n_in = 1'b1;
    host_wr_valid = 1'b1; host_wr_addr = 11'd3; host_wr_data = 8'h11;
    clear_req = 1'b0;
    nxt_valid = 1'b0; nxt_addr = '0; nxt_data = '0; nxt_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_hsync", vga_h_sync_n, 1);
    chk("rst_vsync", vga_v_sync_n, 1);
    chk("rst_busy", clear_busy, 0);
    chk("rst_ready", host_wr_ready, 0);
    chk("rst_we", tile_we, 0);
    host_wr_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Tile map setup through the host port during blanking
    host_write(0, 8'h07);
    host_write(1, 8'h08);
    host_write(1200, 8'hAA);
    chk("idle_busy", clear_busy, 0);

    // Host write held off by active video until counter_x reaches 640
    nxt_valid = 1'b1; nxt_addr = 11'd41; nxt_data = 8'h06;
    for (int x = 636; x <= 641; x++) begin
      if (x == 640) push_wr(41, 8'h06);
      step(x, 10, ov(x, 10, 8'h00));
      chk("stall_ready", host_wr_ready, (x == 640));
      if (x == 640) nxt_valid = 1'b0;
    end

    // Pixel rendering
    step(0, 0, ov(0, 0, 8'hFF));
    step(1, 0, ov(1, 0, 8'h00));
    step(16, 5, ov(16, 5, 8'hE0));
    step(17, 5, ov(17, 5, 8'h00));
    step(16, 16, ov(16, 16, 8'h03));
    step(17, 17, ov(17, 17, 8'h00));
    step(31, 16, ov(31, 16, 8'h00));
    step(639, 479, ov(639, 479, 8'h00));
    step(640, 479, 8'h00);

    // Sync alignment: hsync pulse and a short vsync pulse
    for (int x = 650; x <= 760; x++) step(x, 10, 8'h00);
    for (int y = 488; y <= 493; y++) step(BX, y, 8'h00);

    // Full clear, with a host write colliding with the request
    nxt_clr = 1'b1; nxt_valid = 1'b1; nxt_addr = 11'd5; nxt_data = 8'h55;
    step(BX, BY, 8'h00);
    chk("clr_req_ready", host_wr_ready, 0);
    nxt_clr = 1'b0;
    for (int i = 0; i < 1200; i++) push_wr(i, 8'h00);
    k = 0;
    do begin
      if ((k % 100) < 30) step(k % 100, 100, ov(k % 100, 100, 8'h00));
      else                step(BX, BY, 8'h00);
      if (k == 0) chk("clr_busy_start", clear_busy, 1);
      if (nxt_valid) chk("clr_host_blocked", host_wr_ready, 0);
      if (k == 9) nxt_valid = 1'b0;
      k++;
    end while (clear_busy && k < 4000);
    chk("clr_timeout", (k < 4000), 1);
    chk("clr_done", clear_busy, 0);
    chk("clr_writes_left", wq.size(), 0);
    nz = 0;
    for (int i = 0; i < 1200; i++) if (tile_mem[i] != 8'h00) nz++;
    chk("map_zero", nz, 0);
    step(0, 0, ov(0, 0, 8'h00));
    step(16, 16, ov(16, 16, 8'h00));
    step(16, 5, ov(16, 5, 8'h00));

    // Reset mid-clear aborts the sweep
    host_write(10, 8'h44);
    host_write(600, 8'h33);
    nxt_clr = 1'b1;
    step(BX, BY, 8'h00);
    nxt_clr = 1'b0;
    for (int i = 0; i < 500; i++) push_wr(i, 8'h00);
    repeat (500) step(BX, BY, 8'h00);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", clear_busy, 0);
    chk("abort_hsync", vga_h_sync_n, 1);
    chk("abort_vsync", vga_v_sync_n, 1);
    chk("abort_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("abort_we", tile_we, 0);
    chk("abort_writes_left", wq.size(), 0);
    pq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) step(BX, BY, 8'h00);
    chk("abort_busy_after", clear_busy, 0);
    chk("abort_cleared_tile", tile_mem[10], 8'h00);
    chk("abort_kept_tile", tile_mem[600], 8'h33);

    repeat (4) step(BX, BY, 8'h00);
    repeat (4) @(negedge clk);
    chk("pix_queue_drained", pq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA sync/counter generator.
- Consumes the raw pixel counters and active-low sync pulses, reads a 40x30 tile map and a 16x16 1-bpp glyph ROM, and drives 8-bit RGB plus pipeline-aligned syncs to the VGA connector.
- Owns the single-port tile-map RAM. Arbitrates renderer reads, host writes and a built-in clear-screen sequencer.

Parameters:
- TILE_COLS, 40, tiles per row (640/16)
- TILE_ROWS, 30, tile rows (480/16)
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- counter_x  in  10  column counter from sync generator
- counter_y  in  10  row counter from sync generator
- h_sync_n_in  in  1  active-low hsync; lags counters by 1 cycle
- v_sync_n_in  in  1  active-low vsync; lags counters by 1 cycle
- tile_addr  out  11  tile RAM address
- tile_we  out  1  tile RAM write enable
- tile_wdata  out  8  tile RAM write data
- tile_rdata  in  8  tile RAM read data; 1-cycle read latency. Bits [7:2] are the glyph index, bits [1:0] the palette index.
- glyph_addr  out  10  {glyph[5:0], row[3:0]}
- glyph_data  in  16  glyph row; 1-cycle latency; bit 15 is the leftmost pixel
- host_wr_valid  in  1  host tile write request
- host_wr_addr  in  11  0..1199
- host_wr_data  in  8  tile value
- host_wr_ready  out  1  write accepted this cycle
- clear_req  in  1  single-cycle pulse: zero the whole tile map
- clear_busy  out  1  high while clear is in progress
- vga_r  out  3  red
- vga_g  out  3  green
- vga_b  out  2  blue
- vga_h_sync_n  out  1  hsync, aligned with RGB
- vga_v_sync_n  out  1  vsync, aligned with RGB

Behaviour:
Reset (async, active-high):
- All outputs are 0, except vga_h_sync_n and vga_v_sync_n, which are 1.
- Clear FSM goes to IDLE. Pipeline valid bits are cleared.
- Reset asserted mid-clear aborts the clear; the partially cleared map is left as-is.

Active area:
- active0 = (counter_x < H_ACTIVE) && (counter_y < V_ACTIVE), evaluated combinationally at stage 0.

Pipeline (RGB is registered 3 cycles after the counters):
- S0: if active0, tile_addr = row*40 + col, where row = counter_y[8:4] and col = counter_x[9:4]. Compute as (row<<5)+(row<<3)+col. tile_we = 0. Register x[3:0], y[3:0], active.
- S1: tile_rdata valid. Drive glyph_addr = {tile_rdata[7:2], y1[3:0]}. Register the palette index, x1[3:0] and active.
- S2: glyph_data valid. pix = glyph_data[15 - x2[3:0]]. Colour = PALETTE[pal] if pix, else BG_COLOUR. Output 0 when not active.
- S3: RGB register.
- Sync inputs pass through a 2-stage delay, so total sync delay from counters is 3 cycles, matching RGB.

Port arbitration (checked each cycle), when active0 is low:
- Priority 1: clear FSM write.
- Priority 2: host write. host_wr_ready = host_wr_valid && !active0 && !clear_busy. On a ready cycle, tile_addr = host_wr_addr, tile_we = 1, tile_wdata = host_wr_data.
- Host addresses >= 1200 are acknowledged and dropped (tile_we = 0).
- During active0, host_wr_ready = 0 and clear is stalled.

Clear FSM:
- IDLE: on clear_req, set clr_ptr = 0 and go to RUN. clear_busy is high in every state except IDLE.
- RUN: each cycle with active0 low, write 0 to clr_ptr and increment. After writing 1199, go to IDLE.
- clear_req while busy is ignored.
- clear_req and host_wr_valid in the same blanking cycle: host_wr_ready = 0 from that cycle on.

Optional Feature:
- Macro: GRID_OVERLAY_EN.
- Defined: pixels with x2[3:0]==0 or y2[3:0]==0 inside the active area are forced to GRID_COLOUR (8'b010_010_01), overriding the glyph.
- Undefined: no overlay; logic is absent.

Decomposition:
- Package vga_tile_pkg holds:
  - TILE_COLS and TILE_ROWS
  - TILE_COUNT = 1200
  - Address and tile-data widths
  - PALETTE[4] constants: red E0, green 1C, blue 03, white FF
  - BG_COLOUR = 00
  - GRID_COLOUR
- One sub-module, vga_tile_clear_fsm: IDLE/RUN states, clr_ptr, clear_busy. Inputs: clear_req, a port-free strobe.

Test Plan:
- Tile 0 = {glyph 1, pal 3}; glyph 1 row 0 = 16'h8000; counters at (0,0) -> RGB = FF three cycles later. Counters at (1,0) -> RGB = 00.
- host write addr 41 (row 1, col 1) = 8'h06 issued during blanking -> ready = 1 and tile_we pulse. During active area -> ready stays 0 until counter_x reaches 640.
- clear_req at frame start -> clear_busy high. Exactly 1200 zero writes, only while !active0. clear_busy drops after the write to 1199; all tiles read back 0.
- Reset asserted when clr_ptr = 500 -> clear_busy = 0 and syncs = 1 immediately (asynchronously). No further writes.
- h_sync_n_in low for counter_x 656..751 (sync lags counters by 1 cycle) -> vga_h_sync_n low exactly 3 cycles after counter_x = 655 and 3 cycles after the counters leave 655..750. Pulse width 96 preserved.
- With GRID_OVERLAY_EN, pixel (16,5) -> RGB = 8'h49 regardless of tile content. Without the macro -> glyph colour.
